// File: rtl/msg_sched_pkg.sv
// rtl/msg_sched_pkg.sv - shared state encoding and message constants for msg_scheduler
package msg_sched_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Default boot banners, right-aligned in a 128-bit message (MSB byte is sent first)
    localparam logic [127:0] BOOT_MSG0_DEF = {32'h0, "CALCULATOR", ASCII_LF, ASCII_CR};
    localparam logic [127:0] BOOT_MSG1_DEF = {32'h0, "----------", ASCII_LF, ASCII_CR};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_BOOT0     = 3'd5,
        S_BOOT1     = 3'd6
    } state_e;

    // Which boot banner, if any, the current LOAD/START/WAIT pass is carrying
    typedef enum logic [1:0] {
        BOOT_NONE  = 2'd0,
        BOOT_MSG_0 = 2'd1,
        BOOT_MSG_1 = 2'd2
    } boot_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select starting one past the pointer
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    // Walk ptr+1, ptr+2, ... ptr (mod NREQ) and take the first requester found
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int cand;
            cand = (int'(ptr) + i) % NREQ;
            if (!grant_valid && req[cand]) begin
                grant_valid        = 1'b1;
                grant_idx          = IW'(cand);
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_scheduler.sv
// rtl/msg_scheduler.sv - round-robin sharing of one message serializer; MSG_SCHED_BOOT_EN adds boot banners
module msg_scheduler
    import msg_sched_pkg::*;
#(
    parameter int DATASIZE    = 128,
    parameter int NREQ        = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter logic [DATASIZE-1:0] BOOT_MSG0 = DATASIZE'(BOOT_MSG0_DEF),
    parameter logic [DATASIZE-1:0] BOOT_MSG1 = DATASIZE'(BOOT_MSG1_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] msg_flat,
    input  logic                     ser_idle,
    output logic                     ser_start,
    output logic [DATASIZE-1:0]      ser_data,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
`ifdef MSG_SCHED_BOOT_EN
    localparam state_e RESET_STATE = S_BOOT0;
`else
    localparam state_e RESET_STATE = S_IDLE;
`endif

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       win_idx_q, win_idx_d;
    logic [NREQ-1:0]     win_oh_q, win_oh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic [DATASIZE-1:0] load_msg;
    logic                in_boot;
    logic                job_end;

    logic [NREQ-1:0]     arb_onehot;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req          (req),
        .ptr          (ptr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .grant_valid  (arb_valid)
    );

`ifdef MSG_SCHED_BOOT_EN
    boot_e boot_q, boot_d;

    // Boot pass tracking: which banner is in flight until both have gone out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) boot_q <= BOOT_NONE;
        else       boot_q <= boot_d;
    end

    // Message source for LOAD: a boot banner while booting, else the winner's message
    always_comb begin
        load_msg = msg_flat[int'(win_idx_q)*DATASIZE +: DATASIZE];
        if (boot_q == BOOT_MSG_0) load_msg = BOOT_MSG0;
        if (boot_q == BOOT_MSG_1) load_msg = BOOT_MSG1;
    end

    assign in_boot = (boot_q != BOOT_NONE);
`else
    logic unused_boot;

    assign load_msg    = msg_flat[int'(win_idx_q)*DATASIZE +: DATASIZE];
    assign in_boot     = 1'b0;
    assign unused_boot = ^{BOOT_MSG0, BOOT_MSG1};
`endif

    // State, pointer, winner, timeout counter and data latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            ptr_q     <= IW'(NREQ - 1);
            win_idx_q <= '0;
            win_oh_q  <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
        end
    end

    // Next-state: grant, load, start, then wait for the serializer to go busy and come back
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        job_end   = 1'b0;
`ifdef MSG_SCHED_BOOT_EN
        boot_d    = boot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    win_idx_d = arb_idx;
                    win_oh_d  = arb_onehot;
                    state_d   = S_LOAD;
                end
            end
`ifdef MSG_SCHED_BOOT_EN
            S_BOOT0: begin
                boot_d  = BOOT_MSG_0;
                state_d = S_LOAD;
            end
            S_BOOT1: begin
                boot_d  = BOOT_MSG_1;
                state_d = S_LOAD;
            end
`endif
            S_LOAD: begin
                data_d  = load_msg;
                state_d = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Counter holds at its last value rather than wrapping
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                if (!ser_idle)              state_d = S_WAIT_DONE;
                else if (cnt_q == CNT_LAST) job_end = 1'b1;
            end
            S_WAIT_DONE: begin
                if (ser_idle) job_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A finished or timed-out job moves the pointer so the next search starts after it
        if (job_end) begin
`ifdef MSG_SCHED_BOOT_EN
            if (boot_q == BOOT_MSG_0) begin
                state_d = S_BOOT1;
            end else if (boot_q == BOOT_MSG_1) begin
                boot_d  = BOOT_NONE;
                state_d = S_IDLE;
            end else begin
                ptr_d   = win_idx_q;
                state_d = S_IDLE;
            end
`else
            ptr_d   = win_idx_q;
            state_d = S_IDLE;
`endif
        end
    end

    // Outputs decoded from state; done and err fire in the cycle the job ends
    always_comb begin
        ser_start = (state_q == S_START);
        busy      = (state_q != S_IDLE);
        err       = (state_q == S_WAIT_ACK) && ser_idle && (cnt_q == CNT_LAST);
        done      = '0;
        if ((state_q == S_WAIT_DONE) && ser_idle && !in_boot) done = win_oh_q;
    end

    assign ser_data = data_q;

endmodule

// File: tb/tb_msg_scheduler.sv
// tb/tb_msg_scheduler.sv - directed self-checking bench for msg_scheduler
module tb_msg_scheduler;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [511:0] msg_flat;
    logic         ser_idle;
    logic         ser_start;
    logic [127:0] ser_data;
    logic [3:0]   done;
    logic         err;
    logic         busy;

    logic [127:0] msgs [4];
    logic [127:0] msg2_orig;
    int           n_cmp = 0;
    int           n_bad = 0;

    msg_scheduler #(
        .DATASIZE    (128),
        .NREQ        (4),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .msg_flat  (msg_flat),
        .ser_idle  (ser_idle),
        .ser_start (ser_start),
        .ser_data  (ser_data),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load_flat();
        for (int i = 0; i < 4; i++) msg_flat[i*128 +: 128] = msgs[i];
    endtask

    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc();
            seen = ser_start;
        end
        check(tag, 128'(seen), 128'd1);
    endtask

    task automatic serve(input int exp, input bit drop);
        wait_start("rr_start");
        check("rr_data", ser_data, msgs[exp]);
        cyc();
        ser_idle = 1'b0;
        repeat (20) cyc();
        ser_idle = 1'b1;
        if (drop) req = 4'b0000;
        #1;
        check("rr_done", 128'(done), 128'd1 << exp);
        cyc();
        check("rr_done_clear", 128'(done), 128'd0);
    endtask

    initial begin
        logic any_start, any_busy, any_done, errs;

        reset    = 1'b1;
        req      = 4'b0000;
        ser_idle = 1'b1;
        msgs[0]  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        msgs[1]  = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
        msgs[2]  = {40'h0, "RESULT=42", 8'h0A, 8'h0D};
        msgs[3]  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        msg2_orig = msgs[2];
        load_flat();

        // Reset values
        cyc();
        cyc();
        check("rst_start", 128'(ser_start), 128'd0);
        check("rst_busy",  128'(busy),      128'd0);
        check("rst_done",  128'(done),      128'd0);
        check("rst_err",   128'(err),       128'd0);
        check("rst_data",  ser_data,        128'd0);
        reset = 1'b0;

        // No requests for 100 cycles: nothing happens
        any_start = 1'b0;
        any_busy  = 1'b0;
        any_done  = 1'b0;
        repeat (100) begin
            cyc();
            any_start |= ser_start;
            any_busy  |= busy;
            any_done  |= |done;
        end
        check("idle_start", 128'(any_start), 128'd0);
        check("idle_busy",  128'(any_busy),  128'd0);
        check("idle_done",  128'(any_done),  128'd0);

        // Single request on 2: start in third cycle, one-cycle pulse, latched data
        req = 4'b0100;
        cyc();
        check("lat_load_start", 128'(ser_start), 128'd0);
        check("lat_load_busy",  128'(busy),      128'd1);
        cyc();
        check("lat_start",      128'(ser_start), 128'd1);
        check("lat_data",       ser_data,        msg2_orig);
        msgs[2] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        load_flat();
        cyc();
        check("start_one_cycle", 128'(ser_start), 128'd0);
        ser_idle = 1'b0;
        any_done = 1'b0;
        repeat (50) begin
            cyc();
            any_done |= |done;
        end
        check("no_early_done", 128'(any_done), 128'd0);
        ser_idle = 1'b1;
        req      = 4'b0000;
        #1;
        check("done2",      128'(done), 128'h4);
        check("done2_busy", 128'(busy), 128'd1);
        cyc();
        check("busy_fall",  128'(busy), 128'd0);
        check("done2_clear", 128'(done), 128'd0);
        check("data_held",  ser_data,   msg2_orig);
        msgs[2] = msg2_orig;
        load_flat();

        // Reset while in WAIT_DONE clears outputs without waiting for a clock edge
        req = 4'b0010;
        wait_start("rst_mid_start");
        check("rst_mid_data", ser_data, msgs[1]);
        cyc();
        ser_idle = 1'b0;
        repeat (5) cyc();
        #4;
        reset = 1'b1;
        #1;
        check("async_busy",  128'(busy),      128'd0);
        check("async_start", 128'(ser_start), 128'd0);
        check("async_data",  ser_data,        128'd0);
        check("async_done",  128'(done),      128'd0);
        ser_idle = 1'b1;
        req      = 4'b0000;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // All requesting: strict rotation from requester 0 after reset
        req = 4'b1111;
        serve(0, 1'b0);
        serve(1, 1'b0);
        serve(2, 1'b0);
        serve(3, 1'b0);
        serve(0, 1'b1);

        // Serializer never leaves idle: err in the 16th WAIT_ACK cycle, no done
        req = 4'b0010;
        wait_start("to_start");
        check("to_data", ser_data, msgs[1]);
        errs = 1'b0;
        repeat (15) begin
            cyc();
            errs |= err;
        end
        check("to_no_early_err", 128'(errs), 128'd0);
        cyc();
        check("to_err",  128'(err),  128'd1);
        check("to_done", 128'(done), 128'd0);
        check("to_busy", 128'(busy), 128'd1);
        req = 4'b0111;
        cyc();
        check("to_err_clear", 128'(err),  128'd0);
        check("to_idle",      128'(busy), 128'd0);
        serve(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
